// File: rtl/lcd_cmd_seq.sv
// rtl/lcd_cmd_seq.sv - LCD controller command sequencer (FIFO + issue FSM); optional LCD_CMD_FILTER_EN rejects codes 12-15
module lcd_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       host_cmd,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             lcd_busy,
    input  logic             lcd_done,
    output logic [3:0]       cmd,
    output logic             cmd_valid,
    output logic             seq_idle,
    output logic [CNT_W-1:0] cmd_count,
    output logic             err_illegal
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        LOAD, READY, ACK, WAIT_FREE, WAIT_DONE, WAIT_RELOAD
    } state_t;

    state_t         state, state_next;
    logic [3:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           push_req, push, pop, illegal;

    assign host_ready = (count != FULL_CNT);
    assign push_req   = host_valid && host_ready;
    assign push       = push_req && !illegal;
    assign seq_idle   = (count == '0) && (state == READY);

`ifdef LCD_CMD_FILTER_EN
    // Rejected codes still complete the handshake so the host never stalls on them
    assign illegal = (host_cmd[3:2] == 2'b11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_illegal <= 1'b0;
        else        err_illegal <= push_req && illegal;
    end
`else
    assign illegal     = 1'b0;
    assign err_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_cmd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_next;
    end

    // cmd holds the code under acknowledgement, so ACK can classify it directly
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            LOAD:        if (!lcd_busy) state_next = READY;
            READY: begin
                if ((count != '0) && !lcd_busy) begin
                    pop        = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:         if (lcd_busy) state_next = (cmd == 4'd0) ? WAIT_DONE : WAIT_FREE;
            WAIT_FREE:   if (!lcd_busy) state_next = READY;
            WAIT_DONE:   if (lcd_done) state_next = WAIT_RELOAD;
            WAIT_RELOAD: if (lcd_busy) state_next = LOAD;
            default:     state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
            cmd_count <= '0;
        end else begin
            cmd_valid <= pop;
            if (pop) begin
                cmd       <= mem[rd_ptr];
                cmd_count <= cmd_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb/tb_lcd_cmd_seq.sv - directed self-checking bench for lcd_cmd_seq
module tb_lcd_cmd_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic       lcd_busy;
    logic       lcd_done;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       seq_idle;
    logic [7:0] cmd_count;
    logic       err_illegal;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int issued[$];
    int issue_t[$];
    int expq[$];
    int err_cnt;
    int ctl;
    int ctl_cnt;
    int t_reload_end;
    logic cv_seen;

    localparam int C_IDLE = 0, C_EXEC = 1, C_WRITE = 2, C_GAP = 3, C_RELOAD = 4;

    lcd_cmd_seq #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
        .host_ready(host_ready), .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .cmd(cmd), .cmd_valid(cmd_valid), .seq_idle(seq_idle),
        .cmd_count(cmd_count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, issued.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk({tag, "_code"}, (i < issued.size()) ? issued[i] : -1, expq[i]);
    endtask

    task automatic push(input logic [3:0] code);
        @(negedge clk);
        host_valid = 1'b1;
        host_cmd   = code;
    endtask

    // Runs a controller model for n cycles: busy for one cycle per ordinary
    // command; a write-out (code 0) holds busy, pulses done, idles, then reloads.
    task automatic run(input int n);
        logic xfer;
        xfer = host_valid && host_ready;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (xfer) host_valid = 1'b0;
            xfer = host_valid && host_ready;
            if (err_illegal) err_cnt++;
            if (cmd_valid) begin
                issued.push_back(int'(cmd));
                issue_t.push_back(cyc);
                lcd_busy = 1'b1;
                if (cmd == 4'd0) begin ctl = C_WRITE; ctl_cnt = 3; end
                else ctl = C_EXEC;
            end else begin
                case (ctl)
                    C_EXEC: begin lcd_busy = 1'b0; ctl = C_IDLE; end
                    C_WRITE: begin
                        if (ctl_cnt == 0) begin
                            lcd_busy = 1'b0; lcd_done = 1'b1; ctl = C_GAP; ctl_cnt = 4;
                        end else ctl_cnt--;
                    end
                    C_GAP: begin
                        lcd_done = 1'b0;
                        if (ctl_cnt == 0) begin lcd_busy = 1'b1; ctl = C_RELOAD; ctl_cnt = 4; end
                        else ctl_cnt--;
                    end
                    C_RELOAD: begin
                        if (ctl_cnt == 0) begin lcd_busy = 1'b0; ctl = C_IDLE; t_reload_end = cyc; end
                        else ctl_cnt--;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        reset = 1'b0; host_cmd = 4'd0; host_valid = 1'b0;
        lcd_busy = 1'b1; lcd_done = 1'b0; ctl = C_IDLE; ctl_cnt = 0; err_cnt = 0;
        t_reload_end = 0;

        // Reset and initial image load
        repeat (3) @(negedge clk);
        chk("rst_cmd", cmd, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_host_ready", host_ready, 1);
        chk("rst_seq_idle", seq_idle, 0);
        reset = 1'b1;
        cv_seen = 1'b0;
        repeat (66) begin
            @(negedge clk);
            cv_seen = cv_seen | cmd_valid;
        end
        chk("load_no_issue", cv_seen, 0);
        chk("load_not_idle", seq_idle, 0);
        lcd_busy = 1'b0;
        @(negedge clk);
        chk("ready_idle", seq_idle, 1);
        chk("ready_host_ready", host_ready, 1);

        // Single issue: two cycles from push edge to strobe, no bypass
        push(4'd3);
        @(negedge clk);
        host_valid = 1'b0;
        chk("single_no_bypass", cmd_valid, 0);
        @(negedge clk);
        chk("single_valid", cmd_valid, 1);
        chk("single_cmd", cmd, 3);
        chk("single_count", cmd_count, 1);
        lcd_busy = 1'b1;
        @(negedge clk);
        chk("single_one_pulse", cmd_valid, 0);
        lcd_busy = 1'b0;
        repeat (10) @(negedge clk);
        chk("single_cmd_hold", cmd, 3);
        chk("single_count_hold", cmd_count, 1);
        chk("single_idle", seq_idle, 1);
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        @(negedge clk);
        chk("done_ignored_idle", seq_idle, 1);
        chk("done_ignored_valid", cmd_valid, 0);

        // Back-pressure: fill the FIFO while the controller is busy
        lcd_busy = 1'b1;
        push(4'd4); push(4'd5); push(4'd6);
        @(negedge clk);
        chk("bp_ready_3", host_ready, 1);
        host_cmd = 4'd7;
        @(negedge clk);
        chk("bp_ready_full", host_ready, 0);
        host_cmd = 4'd8;
        repeat (2) @(negedge clk);
        chk("bp_still_full", host_ready, 0);
        chk("bp_no_issue", cmd_valid, 0);
        lcd_busy = 1'b0;
        issued.delete(); issue_t.delete();
        run(40);
        expq = {4, 5, 6, 7, 8};
        chk_seq("bp_order");
        for (int i = 1; i < issue_t.size(); i++)
            chk("bp_spacing", (issue_t[i] - issue_t[i-1]) >= 3, 1);
        chk("bp_count", cmd_count, 6);

        // Frame close: 2 waits for done and a full reload
        lcd_busy = 1'b1;
        push(4'd9); push(4'd0); push(4'd2);
        @(negedge clk);
        host_valid = 1'b0;
        lcd_busy = 1'b0;
        issued.delete(); issue_t.delete();
        run(60);
        expq = {9, 0, 2};
        chk_seq("frame_order");
        chk("frame_after_reload", (issue_t.size() == 3) && (issue_t[2] > t_reload_end) && (t_reload_end > 0), 1);
        chk("frame_count", cmd_count, 9);

        // Illegal code 13
        issued.delete(); issue_t.delete(); err_cnt = 0;
        push(4'd13);
        run(12);
`ifdef LCD_CMD_FILTER_EN
        expq = {};
        chk_seq("illegal_drop");
        chk("illegal_err_pulses", err_cnt, 1);
        chk("illegal_count", cmd_count, 9);
`else
        expq = {13};
        chk_seq("illegal_issue");
        chk("illegal_err_pulses", err_cnt, 0);
        chk("illegal_count", cmd_count, 10);
`endif
        chk("illegal_host_ready", host_ready, 1);

        // Mid-operation reset during ACK with three codes still queued
        lcd_busy = 1'b1;
        push(4'd1); push(4'd2); push(4'd3); push(4'd5);
        @(negedge clk);
        host_valid = 1'b0;
        lcd_busy = 1'b0;
        @(negedge clk);
        chk("mid_in_ack", cmd_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_cmd_valid", cmd_valid, 0);
        chk("mid_cmd", cmd, 0);
        chk("mid_count", cmd_count, 0);
        chk("mid_err", err_illegal, 0);
        chk("mid_host_ready", host_ready, 1);
        chk("mid_seq_idle", seq_idle, 0);
        lcd_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        lcd_busy = 1'b0;
        ctl = C_IDLE;
        issued.delete(); issue_t.delete();
        run(15);
        expq = {};
        chk_seq("mid_flushed");
        chk("mid_idle_after", seq_idle, 1);
        push(4'd6);
        run(10);
        expq = {6};
        chk_seq("mid_new_push");
        chk("mid_new_count", cmd_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
